axi_lite_cmd_master: RTL and testbench

Converts a simple single-beat command/response interface into AXI4-Lite master transactions. It is the upstream driver for AXI-Lite register slaves such as the demo register block, and is used by bring-up sequencers and debug bridges. It issues one outstanding transaction at a time and guards every transaction with a timeout. Responses are returned on a valid/ready response channel.

---
 rtl/axi_lite_cmd_master_pkg.sv | 18 +
 rtl/axi_lite_timeout_counter.sv | 26 ++
 rtl/axi_lite_cmd_master.sv | 206 ++++++++++++++++++++
 tb/tb_axi_lite_cmd_master.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_cmd_master_pkg.sv
// Shared definitions for the AXI4-Lite command master: response codes and FSM states.
package axi_lite_cmd_master_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_WR_ADDR_DATA = 3'd1,
    ST_WR_RESP      = 3'd2,
    ST_RD_ADDR      = 3'd3,
    ST_RD_DATA      = 3'd4,
    ST_RESP         = 3'd5
  } state_e;

endpackage

// File: rtl/axi_lite_timeout_counter.sv
// Saturating transaction timer; expired is high once the count reaches TIMEOUT_CYCLES-1.
module axi_lite_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic i_axi_clk,
  input  logic i_axi_rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYCLES);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_axi_clk or negedge i_axi_rst) begin
    if (!i_axi_rst)                   count_q <= '0;
    else if (clear)                   count_q <= '0;
    else if (enable && !expired)      count_q <= count_q + 1'b1;
  end

  assign expired = (count_q == LAST);

endmodule

// File: rtl/axi_lite_cmd_master.sv
// Single-outstanding AXI4-Lite master driven by a valid/ready command/response interface.
module axi_lite_cmd_master
  import axi_lite_cmd_master_pkg::*;
#(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int STROBE_WIDTH   = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    i_axi_clk,
  input  logic                    i_axi_rst,
  input  logic                    i_cmd_valid,
  output logic                    o_cmd_ready,
  input  logic                    i_cmd_write,
  input  logic [ADDR_WIDTH-1:0]   i_cmd_addr,
  input  logic [DATA_WIDTH-1:0]   i_cmd_wdata,
  input  logic [STROBE_WIDTH-1:0] i_cmd_wstrb,
  output logic                    o_rsp_valid,
  input  logic                    i_rsp_ready,
  output logic [DATA_WIDTH-1:0]   o_rsp_rdata,
  output logic [1:0]              o_rsp_resp,
  output logic                    o_rsp_timeout,
  output logic                    o_awvalid,
  output logic [ADDR_WIDTH-1:0]   o_awaddr,
  input  logic                    i_awready,
  output logic                    o_wvalid,
  output logic [DATA_WIDTH-1:0]   o_wdata,
  output logic [STROBE_WIDTH-1:0] o_wstrb,
  input  logic                    i_wready,
  input  logic                    i_bvalid,
  output logic                    o_bready,
  input  logic [1:0]              i_bresp,
  output logic                    o_arvalid,
  output logic [ADDR_WIDTH-1:0]   o_araddr,
  input  logic                    i_arready,
  input  logic                    i_rvalid,
  output logic                    o_rready,
  input  logic [1:0]              i_rresp,
  input  logic [DATA_WIDTH-1:0]   i_rdata
);

  state_e                  state_q, state_d;
  logic                    awvalid_d, wvalid_d, arvalid_d, bready_d, rready_d;
  logic                    rsp_valid_d, rsp_timeout_d;
  logic [1:0]              rsp_resp_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_d, wdata_d;
  logic [ADDR_WIDTH-1:0]   awaddr_d, araddr_d;
  logic [STROBE_WIDTH-1:0] wstrb_d;
  logic                    timer_clear, timer_enable, timer_expired, do_timeout;

  axi_lite_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .i_axi_clk (i_axi_clk),
    .i_axi_rst (i_axi_rst),
    .clear     (timer_clear),
    .enable    (timer_enable),
    .expired   (timer_expired)
  );

  assign o_cmd_ready = (state_q == ST_IDLE);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    awvalid_d     = o_awvalid;
    wvalid_d      = o_wvalid;
    arvalid_d     = o_arvalid;
    bready_d      = 1'b0;
    rready_d      = 1'b0;
    rsp_valid_d   = o_rsp_valid;
    rsp_resp_d    = o_rsp_resp;
    rsp_timeout_d = o_rsp_timeout;
    rsp_rdata_d   = o_rsp_rdata;
    awaddr_d      = o_awaddr;
    araddr_d      = o_araddr;
    wdata_d       = o_wdata;
    wstrb_d       = o_wstrb;
    timer_clear   = 1'b0;
    timer_enable  = 1'b0;
    do_timeout    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (i_cmd_valid) begin
          timer_clear = 1'b1;
          if (i_cmd_write) begin
            awaddr_d  = i_cmd_addr;
            wdata_d   = i_cmd_wdata;
            wstrb_d   = i_cmd_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = ST_WR_ADDR_DATA;
          end else begin
            araddr_d  = i_cmd_addr;
            arvalid_d = 1'b1;
            state_d   = ST_RD_ADDR;
          end
        end
      end
      ST_WR_ADDR_DATA: begin
        timer_enable = 1'b1;
        awvalid_d    = o_awvalid & ~i_awready;
        wvalid_d     = o_wvalid & ~i_wready;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = ST_WR_RESP;
        end else if (timer_expired) begin
          do_timeout = 1'b1;
        end
      end
      ST_WR_RESP: begin
        timer_enable = 1'b1;
        bready_d     = 1'b1;
        if (i_bvalid) begin
          bready_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_resp_d    = i_bresp;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = '0;
          state_d       = ST_RESP;
        end else if (timer_expired) begin
          do_timeout = 1'b1;
        end
      end
      ST_RD_ADDR: begin
        timer_enable = 1'b1;
        if (i_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RD_DATA;
        end else if (timer_expired) begin
          do_timeout = 1'b1;
        end
      end
      ST_RD_DATA: begin
        timer_enable = 1'b1;
        rready_d     = 1'b1;
        if (i_rvalid) begin
          rready_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_resp_d    = i_rresp;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = i_rdata;
          state_d       = ST_RESP;
        end else if (timer_expired) begin
          do_timeout = 1'b1;
        end
      end
      ST_RESP: begin
        if (i_rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A hung slave loses the transaction: every channel is released and an error is reported.
    if (do_timeout) begin
      awvalid_d     = 1'b0;
      wvalid_d      = 1'b0;
      arvalid_d     = 1'b0;
      bready_d      = 1'b0;
      rready_d      = 1'b0;
      rsp_valid_d   = 1'b1;
      rsp_resp_d    = RESP_SLVERR;
      rsp_timeout_d = 1'b1;
      rsp_rdata_d   = '0;
      state_d       = ST_RESP;
    end
  end

  always_ff @(posedge i_axi_clk or negedge i_axi_rst) begin
    if (!i_axi_rst) begin
      state_q       <= ST_IDLE;
      o_awvalid     <= 1'b0;
      o_wvalid      <= 1'b0;
      o_arvalid     <= 1'b0;
      o_bready      <= 1'b0;
      o_rready      <= 1'b0;
      o_rsp_valid   <= 1'b0;
      o_rsp_resp    <= RESP_OKAY;
      o_rsp_timeout <= 1'b0;
      o_rsp_rdata   <= '0;
      o_awaddr      <= '0;
      o_araddr      <= '0;
      o_wdata       <= '0;
      o_wstrb       <= '0;
    end else begin
      state_q       <= state_d;
      o_awvalid     <= awvalid_d;
      o_wvalid      <= wvalid_d;
      o_arvalid     <= arvalid_d;
      o_bready      <= bready_d;
      o_rready      <= rready_d;
      o_rsp_valid   <= rsp_valid_d;
      o_rsp_resp    <= rsp_resp_d;
      o_rsp_timeout <= rsp_timeout_d;
      o_rsp_rdata   <= rsp_rdata_d;
      o_awaddr      <= awaddr_d;
      o_araddr      <= araddr_d;
      o_wdata       <= wdata_d;
      o_wstrb       <= wstrb_d;
    end
  end

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Directed bench for axi_lite_cmd_master with a register-slave model and response scoreboard.
module tb_axi_lite_cmd_master;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TMO = 16;

  typedef struct {
    logic [DW-1:0] rdata;
    logic [1:0]    resp;
    logic          tmo;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [SW-1:0] cmd_wstrb = '0;
  logic          rsp_valid, rsp_ready = 1'b0, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic          awvalid, awready = 1'b0, wvalid, wready = 1'b0;
  logic [AW-1:0] awaddr, araddr;
  logic [DW-1:0] wdata;
  logic [SW-1:0] wstrb;
  logic          bvalid = 1'b0, bready;
  logic [1:0]    bresp = 2'b00;
  logic          arvalid, arready = 1'b0;
  logic          rvalid = 1'b0, rready;
  logic [1:0]    rresp = 2'b00;
  logic [DW-1:0] rdata = '0;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  logic [DW-1:0] mem [logic [AW-1:0]];

  axi_lite_cmd_master #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STROBE_WIDTH(SW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_axi_clk(clk), .i_axi_rst(rst_n),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_write(cmd_write),
    .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata), .i_cmd_wstrb(cmd_wstrb),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rsp_rdata),
    .o_rsp_resp(rsp_resp), .o_rsp_timeout(rsp_timeout),
    .o_awvalid(awvalid), .o_awaddr(awaddr), .i_awready(awready),
    .o_wvalid(wvalid), .o_wdata(wdata), .o_wstrb(wstrb), .i_wready(wready),
    .i_bvalid(bvalid), .o_bready(bready), .i_bresp(bresp),
    .o_arvalid(arvalid), .o_araddr(araddr), .i_arready(arready),
    .i_rvalid(rvalid), .o_rready(rready), .i_rresp(rresp), .i_rdata(rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
    return mem.exists(a) ? mem[a] : '0;
  endfunction

  task automatic model_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
    logic [DW-1:0] cur;
    cur = model_read(a);
    for (int b = 0; b < SW; b++)
      if (s[b]) cur[b*8 +: 8] = d[b*8 +: 8];
    mem[a] = cur;
  endtask

  // Presents one command and returns once it has been accepted.
  task automatic send_cmd(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [SW-1:0] s);
    int n;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    n = 0;
    while (!cmd_ready && n < 50) begin
      step();
      n++;
    end
    check("cmd_ready_seen", cmd_ready, 1'b1);
    step();
    cmd_valid = 1'b0;
    cmd_wdata = 32'h5555_AAAA;
    cmd_addr  = 16'hFFFF;
  endtask

  task automatic get_rsp(input string tag);
    exp_t e;
    int n;
    n = 0;
    while (!rsp_valid && n < 50) begin
      step();
      n++;
    end
    check({tag, "_rsp_valid"}, rsp_valid, 1'b1);
    check({tag, "_sb_nonempty"}, sb.size() > 0, 1'b1);
    if (rsp_valid && sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_rdata"}, rsp_rdata, e.rdata);
      check({tag, "_resp"}, rsp_resp, e.resp);
      check({tag, "_timeout"}, rsp_timeout, e.tmo);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check({tag, "_rsp_drop"}, rsp_valid, 1'b0);
    check({tag, "_idle"}, cmd_ready, 1'b1);
  endtask

  task automatic do_read(input string tag, input logic [AW-1:0] a, input logic [1:0] rr);
    send_cmd(1'b0, a, '0, '0);
    check({tag, "_arvalid"}, arvalid, 1'b1);
    check({tag, "_araddr"}, araddr, a);
    sb.push_back('{rdata: model_read(a), resp: rr, tmo: 1'b0});
    arready = 1'b1;
    step();
    arready = 1'b0;
    check({tag, "_arvalid_drop"}, arvalid, 1'b0);
    check({tag, "_rready"}, rready, 1'b1);
    rvalid = 1'b1; rdata = model_read(a); rresp = rr;
    step();
    rvalid = 1'b0; rdata = '0; rresp = 2'b00;
    check({tag, "_rready_drop"}, rready, 1'b0);
  endtask

  initial begin
    int n;
    mem[16'h0008] = 32'h1000_0000;

    #2;
    check("reset_awvalid", awvalid, 1'b0);
    check("reset_rsp_valid", rsp_valid, 1'b0);
    check("reset_bready", bready, 1'b0);
    check("reset_awaddr", awaddr, '0);
    check("reset_wdata", wdata, '0);
    step();
    rst_n = 1'b1;
    step();
    check("idle_cmd_ready", cmd_ready, 1'b1);

    // Write with AW and W accepted on the same cycle
    send_cmd(1'b1, 16'h0004, 32'hDEAD_BEEF, 4'hF);
    check("w1_awvalid", awvalid, 1'b1);
    check("w1_wvalid", wvalid, 1'b1);
    check("w1_awaddr", awaddr, 16'h0004);
    check("w1_wdata", wdata, 32'hDEAD_BEEF);
    check("w1_wstrb", wstrb, 4'hF);
    check("w1_cmd_ready_busy", cmd_ready, 1'b0);
    model_write(awaddr, wdata, wstrb);
    sb.push_back('{rdata: '0, resp: 2'b00, tmo: 1'b0});
    awready = 1'b1; wready = 1'b1;
    step();
    awready = 1'b0; wready = 1'b0;
    check("w1_aw_drop", awvalid, 1'b0);
    check("w1_w_drop", wvalid, 1'b0);
    check("w1_bready", bready, 1'b1);
    bvalid = 1'b1; bresp = 2'b00;
    step();
    bvalid = 1'b0;
    check("w1_bready_drop", bready, 1'b0);
    get_rsp("w1");

    do_read("r1", 16'h0004, 2'b00);
    get_rsp("r1");
    do_read("r2", 16'h0008, 2'b00);
    get_rsp("r2");

    // W accepted three cycles in, AW five cycles after that
    send_cmd(1'b1, 16'h0010, 32'hCAFE_F00D, 4'h3);
    step(); step();
    check("w2_both_held", {awvalid, wvalid}, 2'b11);
    check("w2_wdata_stable", wdata, 32'hCAFE_F00D);
    model_write(awaddr, wdata, wstrb);
    wready = 1'b1;
    step();
    wready = 1'b0;
    check("w2_w_drop", {awvalid, wvalid}, 2'b10);
    for (int i = 0; i < 4; i++) begin
      step();
      check("w2_aw_held", {awvalid, wvalid, bready}, 3'b100);
    end
    awready = 1'b1;
    step();
    awready = 1'b0;
    check("w2_aw_drop", {awvalid, wvalid, bready}, 3'b001);
    sb.push_back('{rdata: '0, resp: 2'b00, tmo: 1'b0});
    bvalid = 1'b1;
    step();
    check("w2_single_b", {bready, rsp_valid}, 2'b01);
    step();
    bvalid = 1'b0;
    check("w2_no_second_b", bready, 1'b0);
    get_rsp("w2");
    check("w2_sb_empty", sb.size(), 0);
    do_read("r3", 16'h0010, 2'b00);
    get_rsp("r3");

    // Error response held while the consumer stalls
    mem[16'h00FC] = 32'h1234_5678;
    do_read("r4", 16'h00FC, 2'b10);
    for (int i = 0; i < 4; i++) begin
      check("r4_hold_valid", rsp_valid, 1'b1);
      check("r4_hold_rdata", rsp_rdata, 32'h1234_5678);
      check("r4_hold_resp", rsp_resp, 2'b10);
      step();
    end
    get_rsp("r4");

    // Hung AR channel triggers the timeout; a late R is not consumed
    send_cmd(1'b0, 16'h0020, '0, '0);
    sb.push_back('{rdata: '0, resp: 2'b10, tmo: 1'b1});
    n = 0;
    while (arvalid && n < 40) begin
      step();
      n++;
    end
    check("tmo_arvalid_cycles", n, TMO);
    check("tmo_rsp_valid", rsp_valid, 1'b1);
    rvalid = 1'b1; rdata = 32'hBAD0_BAD0;
    step();
    check("tmo_late_r_rready", rready, 1'b0);
    rvalid = 1'b0; rdata = '0;
    get_rsp("tmo");
    do_read("r5", 16'h0004, 2'b00);
    get_rsp("r5");

    // Reset asserted mid-transaction while waiting for B
    send_cmd(1'b1, 16'h0030, 32'h0BAD_CAFE, 4'hF);
    awready = 1'b1; wready = 1'b1;
    step();
    awready = 1'b0; wready = 1'b0;
    check("rst_pre_bready", bready, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_outputs", {awvalid, wvalid, arvalid, bready, rready, rsp_valid, rsp_timeout},
          7'b0);
    check("rst_async_addr_data", {awaddr, wdata, rsp_rdata, rsp_resp}, '0);
    step(); step();
    check("rst_no_rsp", rsp_valid, 1'b0);
    rst_n = 1'b1;
    step();
    check("rst_release_ready", cmd_ready, 1'b1);
    check("rst_release_rsp", rsp_valid, 1'b0);
    do_read("r6", 16'h0008, 2'b00);
    get_rsp("r6");

    check("final_sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
